// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters.
// One access in flight at a time. Contention is resolved round-robin against
// the last granted port. All outputs come straight from registers.
module ram_arbiter #(
    parameter int g_RAM_WIDTH = 11,
    parameter int g_RAM_ADDR  = 9
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    // requester 0 (CPU load/store unit)
    input  logic                   i_m0_req,
    input  logic                   i_m0_we,
    input  logic [g_RAM_ADDR-1:0]  i_m0_addr,
    input  logic [g_RAM_WIDTH-1:0] i_m0_wdata,
    output logic                   o_m0_done,
    // requester 1 (debug / program loader)
    input  logic                   i_m1_req,
    input  logic                   i_m1_we,
    input  logic [g_RAM_ADDR-1:0]  i_m1_addr,
    input  logic [g_RAM_WIDTH-1:0] i_m1_wdata,
    output logic                   o_m1_done,
    // shared read data and status
    output logic [g_RAM_WIDTH-1:0] o_rdata,
    output logic                   o_busy,
    // RAM interface
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic                   o_ram_re,
    output logic [g_RAM_ADDR-1:0]  o_ram_addr,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q,      state_d;
    logic                   owner_q,      owner_d;
    logic                   last_owner_q, last_owner_d;
    logic                   op_we_q,      op_we_d;
    logic                   ram_en_q,     ram_en_d;
    logic                   ram_we_q,     ram_we_d;
    logic                   ram_re_q,     ram_re_d;
    logic [g_RAM_ADDR-1:0]  ram_addr_q,   ram_addr_d;
    logic [g_RAM_WIDTH-1:0] ram_data_q,   ram_data_d;
    logic [g_RAM_WIDTH-1:0] rdata_q,      rdata_d;
    logic                   done0_q,      done0_d;
    logic                   done1_q,      done1_d;
    logic                   busy_q,       busy_d;

    // Arbitration: a sole requester wins outright; on a tie the port that
    // was not granted last time wins, so neither side can starve.
    logic                   req_any;
    logic                   grant_sel;
    logic                   sel_we;
    logic [g_RAM_ADDR-1:0]  sel_addr;
    logic [g_RAM_WIDTH-1:0] sel_wdata;

    // Pick the winning port and mux its request fields.
    always_comb begin
        req_any   = i_m0_req | i_m1_req;
        grant_sel = (i_m0_req & i_m1_req) ? ~last_owner_q : i_m1_req;
        sel_we    = grant_sel ? i_m1_we    : i_m0_we;
        sel_addr  = grant_sel ? i_m1_addr  : i_m0_addr;
        sel_wdata = grant_sel ? i_m1_wdata : i_m0_wdata;
    end

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so that every output port is a flop.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        op_we_d      = op_we_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_re_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        rdata_d      = rdata_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    owner_d      = grant_sel;
                    last_owner_d = grant_sel;
                    op_we_d      = sel_we;
                    // strobes become visible during ISSUE
                    ram_en_d     = 1'b1;
                    ram_we_d     = sel_we;
                    ram_re_d     = ~sel_we;
                    ram_addr_d   = sel_addr;
                    ram_data_d   = sel_wdata;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_we_q) begin
                    // write completes as soon as the strobe has been seen
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                // RAM presents read data the cycle after en&re
                rdata_d = i_ram_data;
                done0_d = ~owner_q;
                done1_d = owner_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM state and arbitration history.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;   // port 0 wins the first tie
            op_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            op_we_q      <= op_we_d;
        end
    end

    // Registered outputs; reset aborts any access without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            rdata_q    <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_re_q   <= ram_re_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            rdata_q    <= rdata_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
        end
    end

    assign o_ram_en   = ram_en_q;
    assign o_ram_we   = ram_we_q;
    assign o_ram_re   = ram_re_q;
    assign o_ram_addr = ram_addr_q;
    assign o_ram_data = ram_data_q;
    assign o_rdata    = rdata_q;
    assign o_m0_done  = done0_q;
    assign o_m1_done  = done1_q;
    assign o_busy     = busy_q;

endmodule
